// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  // Decimal digits needed for 2^w-1; 1233/4096 approximates log10(2).
  function automatic int unsigned bcd_digits(input int unsigned w);
    return ((w * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Per-digit add-3 cell used by bin2bcd_seq before every shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  // Codes 10..15 never occur in a valid BCD digit; they map to 0.
  always_comb begin
    if (x < BCD_ADJ_THRESH) begin
      y = x;
    end else if (x <= 4'd9) begin
      y = x + 4'd3;
    end else begin
      y = '0;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Define BIN2BCD_SIGNED_EN to treat in_bin as two's complement (sign on sign_o).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter  int unsigned W = 8,
  localparam int unsigned D = bcd_digits(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] out_bcd,
  output logic           sign_o
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [4*D-1:0]   bcd_q, bcd_d;
  logic [4*D-1:0]   bcd_adj;
  logic [W-1:0]     load_mag;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .x (bcd_q[4*g +: 4]),
      .y (bcd_adj[4*g +: 4])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_d;

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign load_mag = in_bin[W-1] ? (~in_bin + 1'b1) : in_bin;
  assign sign_o   = sign_q;

  always_comb begin
    sign_d = sign_q;
    if (state_q == IDLE && in_valid) begin
      sign_d = in_bin[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end
`else
  assign load_mag = in_bin;
  assign sign_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = load_mag;
          bcd_d   = '0;
          cnt_d   = CW'(W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[4*D-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;

endmodule
